hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 87 ++++++++
 tb/tb_hazard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush generation with post-reset hold, memory-wait freeze and watchdog; define HAZARD_PERF_EN to build the perf counters
module hazard_ctrl #(
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_WAIT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idex_memrd,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_use_rt,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        mem_busy,
  output logic        pc_wr_en,
  output logic        ifid_wr_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_wr_en,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  typedef enum logic [1:0] {HOLD, RUN, FREEZE} state_t;
  state_t     state_q;
  logic [3:0] hold_q;
  logic [7:0] wait_q;
  logic       timeout_q;
  logic       hold, busy, load_use, br, lu, jp;
  assign hold        = state_q == HOLD;
  assign busy        = mem_busy & ~timeout_q;
  assign load_use    = idex_memrd && idex_rt != 5'd0 &&
                       (idex_rt == ifid_rs || (ifid_use_rt && idex_rt == ifid_rt));
  assign br          = ~hold & ~busy & ex_branch_taken;
  assign lu          = ~hold & ~busy & ~ex_branch_taken & load_use;
  assign jp          = ~hold & ~busy & ~ex_branch_taken & ~load_use & id_jump;
  assign pc_wr_en    = ~hold & ~busy & ~lu;
  assign ifid_wr_en  = pc_wr_en;
  assign ifid_flush  = hold | br | jp;
  assign idex_flush  = hold | br | lu;
  assign exmem_wr_en = hold | ~busy;
  assign mem_timeout = timeout_q;
  // sequencer: hold after reset, freeze while memory is busy, trip the watchdog on overlong waits
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= HOLD;
      hold_q    <= 4'd0;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        HOLD:
          if (hold_q == 4'(HOLD_CYCLES - 1)) state_q <= RUN;
          else hold_q <= hold_q + 4'd1;
        RUN:
          if (busy) begin
            state_q <= FREEZE;
            wait_q  <= 8'd0;
          end
        FREEZE:
          if (!busy) state_q <= RUN;
          else if (wait_q == 8'(MAX_WAIT - 2)) begin
            timeout_q <= 1'b1;
            state_q   <= RUN;
          end else wait_q <= wait_q + 8'd1;
        default: state_q <= HOLD;
      endcase
    end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q;
  // saturating counts of load-use stall cycles and branch/jump flush cycles
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (lu && ~&stall_q) stall_q <= stall_q + 32'd1;
      if ((br | jp) && ~&flush_q) flush_q <= flush_q + 32'd1;
    end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [4:0] NORM = 5'b11001;
  localparam logic [4:0] HLD  = 5'b00111;
  localparam logic [4:0] FRZ  = 5'b00000;
  localparam logic [4:0] LU   = 5'b00011;
  localparam logic [4:0] BR   = 5'b11111;
  localparam logic [4:0] JP   = 5'b11101;

  typedef struct packed {
    logic       memrd;
    logic [4:0] rt, rs, irt;
    logic       use_rt, br, jmp, busy;
  } stim_t;

  logic clk = 1'b0, rst = 1'b0;
  logic idex_memrd, ifid_use_rt, ex_branch_taken, id_jump, mem_busy;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic pc_wr_en, ifid_wr_en, ifid_flush, idex_flush, exmem_wr_en, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic [69:0] obs_v, e;
  stim_t sq[$];
  logic [69:0] eq[$];
  int checks = 0, errors = 0, exp_stall = 0, exp_flush = 0;

  hazard_ctrl #(.HOLD_CYCLES(2), .MAX_WAIT(64)) dut (
    .clk(clk), .rst(rst), .idex_memrd(idex_memrd), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_busy(mem_busy),
    .pc_wr_en(pc_wr_en), .ifid_wr_en(ifid_wr_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_wr_en(exmem_wr_en), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign obs_v = {pc_wr_en, ifid_wr_en, ifid_flush, idex_flush, exmem_wr_en,
                  mem_timeout, stall_cnt, flush_cnt};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1);
  end

  function automatic logic [31:0] perf(input int n);
    return PERF ? 32'(n) : 32'h0;
  endfunction

  task automatic drive(input stim_t s);
    {idex_memrd, idex_rt, ifid_rs, ifid_rt, ifid_use_rt, ex_branch_taken, id_jump, mem_busy} = s;
  endtask

  task automatic push(input logic memrd, input logic [4:0] rt, rs, irt,
                      input logic use_rt, br, jmp, busy, input logic [4:0] eo, input logic et);
    sq.push_back({memrd, rt, rs, irt, use_rt, br, jmp, busy});
    eq.push_back({eo, et, perf(exp_stall), perf(exp_flush)});
    if (eo == LU) exp_stall++;
    if (eo == BR || eo == JP) exp_flush++;
  endtask

  task automatic test_reset;
    push(0, 0, 0, 0, 0, 0, 0, 0, HLD, 0);
    drive(sq.pop_front());
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = eq.pop_front();
    checks++;
    if (obs_v !== e) begin errors++; $display("FAIL reset_value: got %h expected %h", obs_v, e); end
    @(posedge clk); #1;
    rst = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0, 0, HLD, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, HLD, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
    for (int i = 0; sq.size() > 0; i++) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      checks++;
      if (obs_v !== e) begin errors++; $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs_v, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use;
    push(1, 5, 5, 0, 0, 0, 0, 0, LU, 0);
    push(0, 5, 5, 0, 0, 0, 0, 0, NORM, 0);
    push(1, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
    push(1, 7, 3, 7, 1, 0, 0, 0, LU, 0);
    push(1, 7, 3, 7, 0, 0, 0, 0, NORM, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
    for (int i = 0; sq.size() > 0; i++) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      checks++;
      if (obs_v !== e) begin errors++; $display("FAIL load_use[%0d]: got %h expected %h", i, obs_v, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_priority;
    push(1, 5, 5, 0, 0, 1, 1, 0, BR, 0);
    push(0, 0, 0, 0, 0, 0, 1, 0, JP, 0);
    push(1, 5, 5, 0, 0, 0, 1, 0, LU, 0);
    push(0, 0, 0, 0, 0, 1, 0, 0, BR, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
    for (int i = 0; sq.size() > 0; i++) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      checks++;
      if (obs_v !== e) begin errors++; $display("FAIL branch_priority[%0d]: got %h expected %h", i, obs_v, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait;
    repeat (3) push(0, 0, 0, 0, 0, 0, 0, 1, FRZ, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
    push(1, 5, 5, 0, 0, 1, 0, 1, FRZ, 0);
    push(1, 5, 5, 0, 0, 0, 1, 1, FRZ, 0);
    push(1, 5, 5, 0, 0, 0, 0, 0, LU, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
    for (int i = 0; sq.size() > 0; i++) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      checks++;
      if (obs_v !== e) begin errors++; $display("FAIL mem_wait[%0d]: got %h expected %h", i, obs_v, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog;
    repeat (64) push(0, 0, 0, 0, 0, 0, 0, 1, FRZ, 0);
    repeat (6) push(0, 0, 0, 0, 0, 0, 0, 1, NORM, 1);
    push(0, 0, 0, 0, 0, 0, 0, 0, NORM, 1);
    push(0, 0, 0, 0, 0, 1, 0, 1, BR, 1);
    push(0, 0, 0, 0, 0, 0, 0, 1, NORM, 1);
    for (int i = 0; sq.size() > 0; i++) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      checks++;
      if (obs_v !== e) begin errors++; $display("FAIL watchdog[%0d]: got %h expected %h", i, obs_v, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_freeze;
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    push(0, 0, 0, 0, 0, 0, 0, 1, HLD, 0);
    drive(sq.pop_front());
    #1;
    e = eq.pop_front();
    checks++;
    if (obs_v !== e) begin errors++; $display("FAIL reset_clears_timeout: got %h expected %h", obs_v, e); end
    @(posedge clk); #1;
    rst = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0, 0, HLD, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, HLD, 0);
    repeat (4) push(0, 0, 0, 0, 0, 0, 0, 1, FRZ, 0);
    for (int i = 0; sq.size() > 0; i++) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      checks++;
      if (obs_v !== e) begin errors++; $display("FAIL freeze_before_reset[%0d]: got %h expected %h", i, obs_v, e); end
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0, 1, HLD, 0);
    drive(sq.pop_front());
    #1;
    e = eq.pop_front();
    checks++;
    if (obs_v !== e) begin errors++; $display("FAIL async_reset_in_freeze: got %h expected %h", obs_v, e); end
    @(posedge clk); #1;
    rst = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0, 0, HLD, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, HLD, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
    push(1, 5, 5, 0, 0, 0, 0, 0, LU, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0);
    for (int i = 0; sq.size() > 0; i++) begin
      drive(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      checks++;
      if (obs_v !== e) begin errors++; $display("FAIL rehold[%0d]: got %h expected %h", i, obs_v, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_branch_priority;
    test_mem_wait;
    test_watchdog;
    test_reset_freeze;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
